// File: rtl/periph_io.sv
// Memory-mapped I/O peripheral: 32-bit auto-reload timer with interrupt, LED
// register, synchronized switch inputs and a static/scanned 7-segment display.
module periph_io #(
   parameter logic [31:0] BASE      = 32'h4000_0000,
   parameter int          SW_WIDTH  = 8,
   parameter int          LED_WIDTH = 8,
   parameter int          DIGITS    = 4,
   parameter int          SCAN_DIV  = 4
) (
   input  logic                    sysclk,
   input  logic                    Reset_n,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   input  logic                    we,
   output logic [31:0]             rdata,
   output logic                    irq,
   input  logic [SW_WIDTH-1:0]     switch,
   output logic [LED_WIDTH-1:0]    led,
   output logic [7*DIGITS-1:0]     digi_seg,
   output logic [DIGITS-1:0]       digi_an
);

   localparam logic [7:0] OFF_TH   = 8'h00;
   localparam logic [7:0] OFF_TL   = 8'h04;
   localparam logic [7:0] OFF_TCON = 8'h08;
   localparam logic [7:0] OFF_LED  = 8'h0C;
   localparam logic [7:0] OFF_SW   = 8'h10;
   localparam logic [7:0] OFF_DISP = 8'h14;
   localparam logic [7:0] OFF_DCON = 8'h18;

   localparam int DISP_W = 4 * DIGITS;
   localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // TCON bit positions
   localparam int T_EN   = 0;
   localparam int T_IE   = 1;
   localparam int T_FLAG = 2;

   logic [31:0]         th;
   logic [31:0]         tl;
   logic [2:0]          tcon;
   logic [DISP_W-1:0]   disp;
   logic                dcon;
   logic [SW_WIDTH-1:0] sw_meta;
   logic [SW_WIDTH-1:0] sw_sync;
   logic [DIV_W-1:0]    div_cnt;
   logic [IDX_W-1:0]    digit_idx;

   logic       sel;
   logic [7:0] offset;
   logic       wr_th, wr_tl, wr_tcon, wr_led, wr_disp, wr_dcon;
   logic       overflow;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   assign sel     = (addr[31:8] == BASE[31:8]);
   assign offset  = addr[7:0];
   assign wr_th   = we && sel && (offset == OFF_TH);
   assign wr_tl   = we && sel && (offset == OFF_TL);
   assign wr_tcon = we && sel && (offset == OFF_TCON);
   assign wr_led  = we && sel && (offset == OFF_LED);
   assign wr_disp = we && sel && (offset == OFF_DISP);
   assign wr_dcon = we && sel && (offset == OFF_DCON);

   assign overflow = tcon[T_EN] && (tl == 32'hFFFF_FFFF);
   assign irq      = tcon[T_IE] & tcon[T_FLAG];

   // ------------------------------------------------------------------
   // Timer: software writes take priority over count/reload, and a TCON
   // write during overflow still latches the flag if it keeps irq enabled.
   // ------------------------------------------------------------------
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order between blocks.
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         th   <= '0;
         tl   <= '0;
         tcon <= '0;
      end else begin
         if (wr_th)
            th <= wdata;

         if (wr_tl)
            tl <= wdata;
         else if (tcon[T_EN])
            tl <= overflow ? th : tl + 32'd1;

         if (wr_tcon) begin
            tcon[T_IE:T_EN] <= wdata[T_IE:T_EN];
            tcon[T_FLAG]    <= wdata[T_FLAG] | (overflow & wdata[T_IE]);
         end else if (overflow && tcon[T_IE]) begin
            tcon[T_FLAG] <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // LED, display and display-control registers
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         led  <= '0;
         disp <= '0;
         dcon <= 1'b0;
      end else begin
         if (wr_led)
            led <= wdata[LED_WIDTH-1:0];
         if (wr_disp)
            disp <= wdata[DISP_W-1:0];
         if (wr_dcon)
            dcon <= wdata[0];
      end
   end

   // Two-flop synchronizer for the asynchronous switch inputs
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= switch;
         sw_sync <= sw_meta;
      end
   end

   // ------------------------------------------------------------------
   // Scan divider and digit index run in both display modes, so switching
   // into scan mode picks up wherever the index currently is.
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt   <= '0;
         digit_idx <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt   <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first; a path that leaves
   // it unassigned would otherwise infer a latch.
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (offset)
            OFF_TH:   rdata = th;
            OFF_TL:   rdata = tl;
            OFF_TCON: rdata[2:0] = tcon;
            OFF_LED:  rdata[LED_WIDTH-1:0] = led;
            OFF_SW:   rdata[SW_WIDTH-1:0] = sw_sync;
            OFF_DISP: rdata[DISP_W-1:0] = disp;
            OFF_DCON: rdata[0] = dcon;
            default:  ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
   // ------------------------------------------------------------------
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   // Static mode lights every digit; scan mode lights only the indexed one.
   always_comb begin
      digi_seg = '1;
      digi_an  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!dcon || (digit_idx == IDX_W'(k))) begin
            digi_an[k]          = 1'b1;
            digi_seg[7*k +: 7]  = hex_to_seg(disp[4*k +: 4]);
         end
      end
   end

endmodule

// File: tb/tb_periph_io.sv
// Self-checking bench for periph_io: directed scenarios plus randomized bus
// traffic compared against a register-level behavioural model.
module tb_periph_io;

   localparam logic [31:0] BASE      = 32'h4000_0000;
   localparam int          SW_WIDTH  = 8;
   localparam int          LED_WIDTH = 8;
   localparam int          DIGITS    = 4;
   localparam int          SCAN_DIV  = 4;

   logic        sysclk = 1'b0;
   logic        Reset_n;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [31:0] rdata;
   logic        irq;
   logic [7:0]  switch;
   logic [7:0]  led;
   logic [27:0] digi_seg;
   logic [3:0]  digi_an;

   periph_io #(
      .BASE      (BASE),
      .SW_WIDTH  (SW_WIDTH),
      .LED_WIDTH (LED_WIDTH),
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV)
   ) dut (
      .sysclk   (sysclk),
      .Reset_n  (Reset_n),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .rdata    (rdata),
      .irq      (irq),
      .switch   (switch),
      .led      (led),
      .digi_seg (digi_seg),
      .digi_an  (digi_an)
   );

   always #5 sysclk = ~sysclk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [31:0] m_th, m_tl;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led;
   logic [15:0] m_disp;
   logic        m_dcon;
   logic [7:0]  sw_hist[$];
   int          m_cyc;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_disp = '0; m_dcon = 1'b0;
      sw_hist.delete();
      m_cyc = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:8] != BASE[31:8]) return 32'h0;
      case (a[7:0])
         8'h00: return m_th;
         8'h04: return m_tl;
         8'h08: return {29'h0, m_tcon};
         8'h0C: return {24'h0, m_led};
         8'h10: return (sw_hist.size() == 2) ? {24'h0, sw_hist[1]} : 32'h0;
         8'h14: return {16'h0, m_disp};
         8'h18: return {31'h0, m_dcon};
         default: return 32'h0;
      endcase
   endfunction

   function automatic int m_idx();
      return (m_cyc / SCAN_DIV) % DIGITS;
   endfunction

   function automatic logic [3:0] m_an();
      return m_dcon ? 4'(1 << m_idx()) : 4'hF;
   endfunction

   function automatic logic [27:0] m_seg();
      logic [27:0] s;
      for (int k = 0; k < DIGITS; k++) begin
         if (m_dcon && (k != m_idx())) s[7*k +: 7] = 7'h7F;
         else                          s[7*k +: 7] = seg_tab[m_disp[4*k +: 4]];
      end
      return s;
   endfunction

   // One rising edge with the inputs currently driven, then settle 1 time unit.
   task automatic step();
      logic        sel_w, ovf;
      logic [7:0]  off, sw_now;
      logic [31:0] n_tl;
      logic [2:0]  n_tcon;
      if (!Reset_n) begin
         @(posedge sysclk);
         #1;
      end else begin
         sel_w  = we && (addr[31:8] == BASE[31:8]);
         off    = addr[7:0];
         sw_now = switch;
         ovf    = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
         n_tl   = m_tl;
         if (sel_w && off == 8'h04) n_tl = wdata;
         else if (m_tcon[0])        n_tl = ovf ? m_th : m_tl + 32'd1;
         n_tcon = m_tcon;
         if (sel_w && off == 8'h08) n_tcon = {wdata[2] | (ovf & wdata[1]), wdata[1:0]};
         else if (ovf && m_tcon[1]) n_tcon[2] = 1'b1;
         @(posedge sysclk);
         m_tl   = n_tl;
         m_tcon = n_tcon;
         if (sel_w && off == 8'h00) m_th   = wdata;
         if (sel_w && off == 8'h0C) m_led  = wdata[7:0];
         if (sel_w && off == 8'h14) m_disp = wdata[15:0];
         if (sel_w && off == 8'h18) m_dcon = wdata[0];
         sw_hist.push_front(sw_now);
         if (sw_hist.size() > 2) void'(sw_hist.pop_back());
         m_cyc++;
         #1;
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      step();
      we = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_irq"},   irq,      m_tcon[1] & m_tcon[2]);
      chk({tag, "_led"},   led,      m_led);
      chk({tag, "_an"},    digi_an,  m_an());
      chk({tag, "_seg"},   digi_seg, m_seg());
      chk({tag, "_rdata"}, rdata,    m_read(addr));
   endtask

   initial begin
      Reset_n = 1'b1; addr = BASE; wdata = '0; we = 1'b0; switch = '0;
      model_reset();
      #2 Reset_n = 1'b0;
      step(); step();

      // Reset state
      chk("rst_irq", irq, 1'b0);
      chk("rst_led", led, 8'h00);
      chk("rst_an",  digi_an, 4'hF);
      chk("rst_seg", digi_seg, {4{7'b1000000}});
      for (int i = 0; i < 8; i++) begin
         addr = BASE + 32'(4 * i);
         #1;
         chk("rst_rd", rdata, 32'h0);
      end
      Reset_n = 1'b1;

      // Timer reload and interrupt
      bus_wr(BASE + 32'h00, 32'hFFFF_FFFD);
      bus_wr(BASE + 32'h04, 32'hFFFF_FFFE);
      bus_wr(BASE + 32'h08, 32'h3);
      addr = BASE + 32'h04; #1;
      chk("tl_after_en", rdata, 32'hFFFF_FFFE);
      step();
      chk("tl_max", rdata, 32'hFFFF_FFFF);
      chk("irq_pre", irq, 1'b0);
      step();
      chk("tl_reload", rdata, 32'hFFFF_FFFD);
      chk("irq_set", irq, 1'b1);
      bus_wr(BASE + 32'h08, 32'h3);
      chk("irq_clr", irq, 1'b0);
      check_outputs("timer");

      // TL write in the overflow cycle wins over the reload
      addr = BASE + 32'h04;
      step();
      chk("tl_max2", rdata, 32'hFFFF_FFFF);
      bus_wr(BASE + 32'h04, 32'h10);
      chk("tl_wr_wins", rdata, 32'h10);
      check_outputs("tl_ovf_wr");
      bus_wr(BASE + 32'h08, 32'h3);

      // TCON write in the overflow cycle keeps the flag when irq stays enabled
      bus_wr(BASE + 32'h04, 32'hFFFF_FFFF);
      bus_wr(BASE + 32'h08, 32'h2);
      chk("tcon_ovf_wr", rdata, 32'h6);
      chk("tcon_ovf_irq", irq, 1'b1);
      check_outputs("tcon_ovf");
      bus_wr(BASE + 32'h08, 32'h0);
      chk("tcon_clr_irq", irq, 1'b0);

      // Switch synchronizer latency
      switch = 8'h02;
      addr = BASE + 32'h10;
      step();
      chk("sw_edge1", rdata, 32'h0);
      step();
      chk("sw_edge2", rdata, 32'h2);

      // LED and static display
      bus_wr(BASE + 32'h0C, 32'hA5);
      chk("led_wr", led, 8'hA5);
      bus_wr(BASE + 32'h14, 32'h0000_1234);
      chk("disp_static", digi_seg, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
      chk("an_static", digi_an, 4'hF);

      // Scan mode
      bus_wr(BASE + 32'h18, 32'h1);
      for (int i = 0; i < 20; i++) begin
         check_outputs("scan");
         step();
      end

      // Unmapped offset and unselected address
      addr = BASE + 32'h1C; #1;
      chk("rd_unmapped", rdata, 32'h0);
      bus_wr(32'h5000_000C, 32'hFF);
      chk("led_unsel_wr", led, 8'hA5);
      addr = 32'h5000_0000; #1;
      chk("rd_unsel", rdata, 32'h0);
      check_outputs("unsel");

      // Randomized bus traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 6)      addr = BASE + 32'(4 * r);
         else if (r == 7) addr = BASE + 32'($urandom_range(8'h1C, 8'hFF));
         else if (r == 8) addr = 32'h5000_0000 | 32'($urandom_range(0, 8'h18));
         else             addr = BASE + 32'($urandom_range(0, 8'hFF));
         we    = ($urandom_range(0, 3) == 0);
         wdata = $urandom;
         if (r == 1 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
         step();
         we = 1'b0;
         check_outputs("rand");
      end

      // Reset pulse mid-scan
      bus_wr(BASE + 32'h18, 32'h1);
      bus_wr(BASE + 32'h0C, 32'h5A);
      step(); step();
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_an",  digi_an, 4'hF);
      chk("midrst_led", led, 8'h00);
      chk("midrst_seg", digi_seg, {4{7'b1000000}});
      chk("midrst_irq", irq, 1'b0);
      step(); step();
      Reset_n = 1'b1;
      addr = BASE + 32'h04;
      check_outputs("post_rst");
      bus_wr(BASE + 32'h18, 32'h1);
      for (int i = 0; i < 12; i++) begin
         check_outputs("post_rst_scan");
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
